neuron_mac_q78: RTL and testbench

//  Streaming neuron pre-activation unit. Takes one (x, w) pair per beat and

---
 rtl/nn_fixed_pkg.sv | 40 ++++
 rtl/fixed_round_sat.sv | 33 +++
 rtl/neuron_mac_q78.sv | 139 +++++++++++++
 tb/tb_neuron_mac_q78.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_fixed_pkg.sv
// Fixed-point types, FSM states and saturation helper shared by
// the neural-network layer stages.
package nn_fixed_pkg;

    localparam int INT_BITS  = 7;
    localparam int FRAC_BITS = 8;
    localparam int W         = 1 + INT_BITS + FRAC_BITS;

    typedef logic signed [W-1:0] fixed_t;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DRAIN,
        HOLD
    } state_t;

    typedef struct packed {
        logic   sat;
        fixed_t z;
    } sat_res_t;

    localparam fixed_t FIXED_MAX = {1'b0, {(W-1){1'b1}}};
    localparam fixed_t FIXED_MIN = {1'b1, {(W-1){1'b0}}};

    function automatic sat_res_t sat_fixed(input logic signed [63:0] v);
        sat_res_t r;
        r.sat = 1'b0;
        r.z   = v[W-1:0];
        if (v > longint'(FIXED_MAX)) begin
            r.sat = 1'b1;
            r.z   = FIXED_MAX;
        end else if (v < longint'(FIXED_MIN)) begin
            r.sat = 1'b1;
            r.z   = FIXED_MIN;
        end
        return r;
    endfunction

endpackage

// File: rtl/fixed_round_sat.sv
// Adds bias to a full-precision Q.(2*FRAC_BITS) sum, rounds half
// toward +inf and saturates to the W-bit fixed-point range.
module fixed_round_sat
    import nn_fixed_pkg::*;
#(
    parameter int AW = 36
) (
    input  logic signed [AW-1:0] acc,
    input  fixed_t               bias,
    output fixed_t               z,
    output logic                 sat
);

    localparam int SW = AW + 1;

    logic signed [SW-1:0] bias_ext;
    logic signed [SW-1:0] rnd;
    logic signed [SW-1:0] sum;
    logic signed [SW-1:0] shifted;
    logic signed [63:0]   wide;
    sat_res_t             res;

    assign bias_ext = $signed({{(SW-W){bias[W-1]}}, bias}) <<< FRAC_BITS;
    assign rnd      = {{(SW-FRAC_BITS){1'b0}}, 1'b1, {(FRAC_BITS-1){1'b0}}};
    assign sum      = $signed({acc[AW-1], acc}) + bias_ext + rnd;
    // Arithmetic shift floors, so the added half gives round-half-up.
    assign shifted  = sum >>> FRAC_BITS;
    assign wide     = {{(64-SW){shifted[SW-1]}}, shifted};
    assign res      = sat_fixed(wide);
    assign z        = res.z;
    assign sat      = res.sat;

endmodule

// File: rtl/neuron_mac_q78.sv
// Streaming neuron pre-activation: dot product plus bias, rounded
// and saturated to signed Q7.8 for the sigmoid stage downstream.
module neuron_mac_q78
    import nn_fixed_pkg::*;
#(
    parameter int N_INPUTS = 16
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   in_valid,
    output logic   in_ready,
    input  fixed_t in_x,
    input  fixed_t in_w,
    input  logic   in_last,
    input  fixed_t bias,
    output logic   out_valid,
    input  logic   out_ready,
    output fixed_t out_z,
    output logic   out_sat
);

    localparam int CW = $clog2(N_INPUTS);
    localparam int PW = 2 * W;
    localparam int AW = PW + CW;

    state_t               state;
    logic [CW-1:0]        count;
    fixed_t               bias_q;
    fixed_t               x_q;
    fixed_t               w_q;
    logic                 v0;
    logic                 f0;
    logic                 v1;
    logic                 f1;
    logic signed [PW-1:0] prod_q;
    logic signed [AW-1:0] prod_ext;
    logic signed [AW-1:0] acc_q;
    fixed_t               z_c;
    logic                 sat_c;
    logic                 hs;
    logic                 vec_end;
    logic                 drained;

    assign hs       = in_valid & in_ready;
    assign vec_end  = in_last | (count == CW'(N_INPUTS - 1));
    assign drained  = !v0 && !v1;
    assign prod_ext = {{CW{prod_q[PW-1]}}, prod_q};

    // Input capture, product and accumulate stages; f* marks a vector's
    // first beat so the accumulator restarts without a separate clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v0     <= 1'b0;
            f0     <= 1'b0;
            v1     <= 1'b0;
            f1     <= 1'b0;
            x_q    <= '0;
            w_q    <= '0;
            prod_q <= '0;
            acc_q  <= '0;
        end else begin
            v0 <= hs;
            f0 <= hs && (state == IDLE);
            v1 <= v0;
            f1 <= f0;
            if (hs) begin
                x_q <= in_x;
                w_q <= in_w;
            end
            if (v0) prod_q <= x_q * w_q;
            if (v1) acc_q <= f1 ? prod_ext : acc_q + prod_ext;
        end
    end

    fixed_round_sat #(
        .AW(AW)
    ) u_round_sat (
        .acc (acc_q),
        .bias(bias_q),
        .z   (z_c),
        .sat (sat_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_z     <= '0;
            out_sat   <= 1'b0;
            count     <= '0;
            bias_q    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (hs) begin
                        bias_q <= bias;
                        if (vec_end) begin
                            count    <= '0;
                            in_ready <= 1'b0;
                            state    <= DRAIN;
                        end else begin
                            count <= count + 1'b1;
                            state <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (hs) begin
                        if (vec_end) begin
                            count    <= '0;
                            in_ready <= 1'b0;
                            state    <= DRAIN;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (drained) begin
                        out_z     <= z_c;
                        out_sat   <= sat_c;
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_mac_q78.sv
// Directed bench for neuron_mac_q78 with an arithmetic reference
// model checked every cycle plus literal expected results.
module tb_neuron_mac_q78;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] in_x;
    logic signed [15:0] in_w;
    logic               in_last;
    logic signed [15:0] bias;
    logic               out_valid;
    logic               out_ready;
    logic [15:0]        out_z;
    logic               out_sat;

    neuron_mac_q78 dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_x     (in_x),
        .in_w     (in_w),
        .in_last  (in_last),
        .bias     (bias),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_z    (out_z),
        .out_sat  (out_sat)
    );

    typedef struct {
        logic [15:0] z;
        logic        sat;
    } exp_t;

    exp_t   exq[$];
    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    int     last_hs = 0;
    longint m_acc = 0;
    longint m_bias = 0;
    int     m_cnt = 0;
    bit     prev_v = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    function automatic exp_t model(longint acc, longint b);
        exp_t   e;
        longint s;
        s = (acc + b * 256 + 128) >>> 8;
        e.sat = (s > 32767) || (s < -32768);
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        e.z = s[15:0];
        return e;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic beat(input logic [15:0] x, input logic [15:0] w,
                        input logic [15:0] b, input logic last);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_x     = x;
        in_w     = w;
        bias     = b;
        in_last  = last;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout got 0 want 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic bubble();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string nm);
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout got 0 want 1", nm);
        end
    endtask

    task automatic get_out(input logic [15:0] z, input logic sat,
                           input string nm, input int hold);
        wait_valid(nm);
        chk({nm, "_z"}, int'(out_z), int'(z));
        chk({nm, "_sat"}, int'(out_sat), int'(sat));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({nm, "_hold_rdy"}, int'(in_ready), 0);
            chk({nm, "_hold_vld"}, int'(out_valid), 1);
            chk({nm, "_hold_z"}, int'(out_z), int'(z));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk({nm, "_post_vld"}, int'(out_valid), 0);
        chk({nm, "_post_rdy"}, int'(in_ready), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic release_rst();
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rdy_after_rst", int'(in_ready), 1);
    endtask

    initial begin
        in_valid  = 1'b0;
        in_x      = '0;
        in_w      = '0;
        in_last   = 1'b0;
        bias      = '0;
        out_ready = 1'b0;
        rst_n     = 1'b1;

        fork
            forever begin
                @(posedge clk);
                cyc++;
            end
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    m_acc  = 0;
                    m_cnt  = 0;
                    prev_v = 0;
                    exq.delete();
                end else begin
                    if (out_valid) begin
                        if (!prev_v) chk("latency", cyc - last_hs, 3);
                        if (exq.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL model_empty got %0h want none", out_z);
                        end else begin
                            chk("model_z", int'(out_z), int'(exq[0].z));
                            chk("model_sat", int'(out_sat), int'(exq[0].sat));
                            if (out_ready) void'(exq.pop_front());
                        end
                    end
                    prev_v = out_valid;
                    if (in_valid && in_ready) begin
                        if (m_cnt == 0) m_bias = longint'(bias);
                        m_acc += longint'(in_x) * longint'(in_w);
                        m_cnt++;
                        if (in_last || m_cnt == 16) begin
                            exq.push_back(model(m_acc, m_bias));
                            m_acc   = 0;
                            m_cnt   = 0;
                            last_hs = cyc + 1;
                        end
                    end
                end
            end
        join_none

        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_z", int'(out_z), 0);
        chk("rst_out_sat", int'(out_sat), 0);
        release_rst();

        beat(16'h0100, 16'h0080, 16'h0000, 1'b0);
        beat(16'h0200, 16'h0080, 16'h0000, 1'b1);
        get_out(16'h0180, 1'b0, "dot2", 0);

        beat(16'h0100, 16'h0100, 16'hFF00, 1'b1);
        get_out(16'h0000, 1'b0, "bias", 0);

        for (int i = 0; i < 4; i++)
            beat(16'h7F00, 16'h0200, 16'h0000, i == 3);
        get_out(16'h7FFF, 1'b1, "sat_pos", 0);

        for (int i = 0; i < 4; i++)
            beat(16'h7F00, 16'hFE00, 16'h0000, i == 3);
        get_out(16'h8000, 1'b1, "sat_neg", 0);

        beat(16'h0001, 16'h0080, 16'h0000, 1'b1);
        get_out(16'h0001, 1'b0, "rnd_p1", 0);
        beat(16'hFFFF, 16'h0080, 16'h0000, 1'b1);
        get_out(16'h0000, 1'b0, "rnd_m1", 0);
        beat(16'h0003, 16'h0080, 16'h0000, 1'b1);
        get_out(16'h0002, 1'b0, "rnd_p3", 0);

        beat(16'h0300, 16'h0100, 16'h0040, 1'b0);
        bubble();
        bubble();
        beat(16'hFF80, 16'h0100, 16'h0000, 1'b1);
        get_out(16'h02C0, 1'b0, "bpress", 5);

        for (int i = 0; i < 16; i++)
            beat(16'h0100, 16'h0100, (i == 0) ? 16'h0000 : 16'h7F00, 1'b0);
        get_out(16'h1000, 1'b0, "forced", 0);
        beat(16'h0100, 16'h0100, 16'h0200, 1'b1);
        get_out(16'h0300, 1'b0, "beat17", 0);

        for (int i = 0; i < 3; i++)
            beat(16'h0100, 16'h0100, 16'h0000, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midvec_out_valid", int'(out_valid), 0);
        chk("midvec_out_z", int'(out_z), 0);
        chk("midvec_in_ready", int'(in_ready), 0);
        release_rst();

        beat(16'h0100, 16'h0100, 16'h0100, 1'b1);
        wait_valid("hold_rst");
        chk("hold_rst_pre_z", int'(out_z), 16'h0200);
        #1;
        rst_n = 1'b0;
        #1;
        chk("hold_rst_out_valid", int'(out_valid), 0);
        chk("hold_rst_out_z", int'(out_z), 0);
        chk("hold_rst_out_sat", int'(out_sat), 0);
        release_rst();

        beat(16'h0100, 16'h0100, 16'h0000, 1'b1);
        get_out(16'h0100, 1'b0, "recover", 0);

        repeat (3) @(negedge clk);
        chk("queue_drained", exq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
